dino_frame_writer: RTL

DINO_FRAME_WRITER -- requirements
Module: dino_frame_writer

---
 rtl/dino_pkg.sv | 73 +++++++
 rtl/dino_sync_edge.sv | 27 ++
 rtl/dino_frame_writer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Shared constants, FSM encoding and frame-word helpers for the dino sprite writer.
package dino_pkg;

  typedef enum logic [8:0] {
    ADDR_DINO_X  = 9'd0,
    ADDR_DINO_Y  = 9'd1,
    ADDR_CLOUD_X = 9'd2,
    ADDR_CLOUD_Y = 9'd3,
    ADDR_L_CAC_X = 9'd4,
    ADDR_L_CAC_Y = 9'd5,
    ADDR_S_CAC_X = 9'd6,
    ADDR_S_CAC_Y = 9'd7,
    ADDR_BIRD_X  = 9'd8,
    ADDR_BIRD_Y  = 9'd9,
    ADDR_SCORE   = 9'd10,
    ADDR_SCORE_X = 9'd11,
    ADDR_SCORE_Y = 9'd12
  } dino_addr_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_UPDATE,
    ST_WRITE
  } dino_state_e;

  localparam int GROUND_Y     = 180;
  localparam int DINO_X       = 40;
  localparam int JUMP_V       = 14;
  localparam int SPEED        = 2;
  localparam int HIT          = 24;
  localparam int CAC_START    = 255;
  localparam int CAC_Y        = 180;
  localparam int SCORE_X      = 35;
  localparam int SCORE_Y      = 441;
  localparam int FRAME_WRITES = 5;

  localparam logic signed [8:0] GROUND_Y_S = 9'(GROUND_Y);
  localparam logic signed [8:0] JUMP_VEL_S = 9'(-JUMP_V);
  localparam logic signed [8:0] HIT_Y_S    = 9'(GROUND_Y - HIT);
  localparam logic [7:0] CAC_START_B = 8'(CAC_START);
  localparam logic [7:0] SPEED_B     = 8'(SPEED);
  localparam logic [7:0] HIT_X_LO    = 8'(DINO_X - HIT);
  localparam logic [7:0] HIT_X_HI    = 8'(DINO_X + HIT);
  localparam logic [2:0] LAST_WRITE  = 3'(FRAME_WRITES - 1);
  localparam logic [31:0] SCORE_X_W  = 32'(SCORE_X);
  // The score row register is only 8 bits wide, so 441 lands on 185.
  localparam logic [31:0] SCORE_Y_W  = {24'd0, 8'(SCORE_Y)};

  function automatic logic [8:0] frame_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    frame_addr = ADDR_DINO_X;
      3'd1:    frame_addr = ADDR_DINO_Y;
      3'd2:    frame_addr = ADDR_S_CAC_X;
      3'd3:    frame_addr = ADDR_S_CAC_Y;
      default: frame_addr = ADDR_SCORE;
    endcase
  endfunction

  function automatic logic [31:0] frame_data(input logic [2:0]        idx,
                                             input logic signed [8:0] dino_y,
                                             input logic [7:0]        cac_x,
                                             input logic [3:0]        score);
    case (idx)
      3'd0:    frame_data = 32'(DINO_X);
      3'd1:    frame_data = {23'd0, dino_y};
      3'd2:    frame_data = {24'd0, cac_x};
      3'd3:    frame_data = 32'(CAC_Y);
      default: frame_data = {28'd0, score};
    endcase
  endfunction

endpackage

// File: rtl/dino_sync_edge.sv
// Two-flop synchronizer for an asynchronous level input, followed by a rising-edge detector.
module dino_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/dino_frame_writer.sv
// Dino game bus master: places the score sprite once, then per frame runs one game step
// and refreshes the dino, cactus and score registers of the sprite peripheral.
//   state     | meaning
//   ST_INIT   | place score sprite (reg 11, then reg 12)
//   ST_IDLE   | wait for the vertical-sync falling edge
//   ST_UPDATE | single-cycle game step
//   ST_WRITE  | refresh regs 0, 1, 6, 7, 10 in that order
module dino_frame_writer
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        VGA_VS,
  input  logic        jump_btn,
  output logic        chipselect,
  output logic        write,
  output logic [8:0]  address,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  output logic        game_over,
  output logic        frame_miss
);

  dino_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d, idx_nx;
  logic        cs_q, cs_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic signed [8:0] dino_y_q, dino_y_d;
  logic signed [8:0] vel_q, vel_d;
  logic signed [8:0] vel_use, vel_next, y_next;
  logic              on_ground_q, on_ground_d;
  logic [7:0]        cac_x_q, cac_x_d;
  logic [3:0]        score_q, score_d;
  logic              game_over_q, game_over_d;
  logic              jump_pending_q, jump_pending_d;
  logic              vs_q;
  logic              frame_miss_q;

  logic jump_edge;
  logic frame_tick;
  logic do_update;
  logic bus_done;

  dino_sync_edge u_jump_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .async_i (jump_btn),
    .rise_o  (jump_edge)
  );

  assign frame_tick = vs_q & ~VGA_VS;
  assign do_update  = (state_q == ST_UPDATE);
  assign bus_done   = cs_q & ~waitrequest;
  assign idx_nx     = idx_q + 3'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_INIT: begin
        if (!cs_q) begin
          cs_d    = 1'b1;
          idx_d   = 3'd0;
          addr_d  = ADDR_SCORE_X;
          wdata_d = SCORE_X_W;
        end else if (!waitrequest) begin
          if (idx_q == 3'd0) begin
            idx_d   = 3'd1;
            addr_d  = ADDR_SCORE_Y;
            wdata_d = SCORE_Y_W;
          end else begin
            cs_d    = 1'b0;
            idx_d   = 3'd0;
            addr_d  = '0;
            wdata_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (frame_tick) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_d = ST_WRITE;
        cs_d    = 1'b1;
        idx_d   = 3'd0;
        addr_d  = frame_addr(3'd0);
        wdata_d = frame_data(3'd0, dino_y_q, cac_x_q, score_q);
      end
      ST_WRITE: begin
        if (bus_done) begin
          if (idx_q == LAST_WRITE) begin
            cs_d    = 1'b0;
            idx_d   = 3'd0;
            addr_d  = '0;
            wdata_d = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_nx;
            addr_d  = frame_addr(idx_nx);
            wdata_d = frame_data(idx_nx, dino_y_q, cac_x_q, score_q);
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    dino_y_d       = dino_y_q;
    vel_d          = vel_q;
    on_ground_d    = on_ground_q;
    cac_x_d        = cac_x_q;
    score_d        = score_q;
    game_over_d    = game_over_q;
    jump_pending_d = jump_pending_q;
    vel_use        = vel_q;
    vel_next       = vel_q;
    y_next         = dino_y_q;
    if (do_update) begin
      jump_pending_d = 1'b0;
      if (game_over_q) begin
        if (jump_pending_q) begin
          dino_y_d    = GROUND_Y_S;
          vel_d       = '0;
          on_ground_d = 1'b1;
          cac_x_d     = CAC_START_B;
          score_d     = '0;
          game_over_d = 1'b0;
        end
      end else begin
        if (jump_pending_q && on_ground_q) begin
          vel_use     = JUMP_VEL_S;
          on_ground_d = 1'b0;
        end
        y_next   = dino_y_q + vel_use;
        vel_next = vel_use + 9'sd1;
        // Landing uses the post-increment velocity so a grounded dino stays put.
        if (vel_next > 9'sd0 && y_next >= GROUND_Y_S) begin
          dino_y_d    = GROUND_Y_S;
          vel_d       = '0;
          on_ground_d = 1'b1;
        end else begin
          dino_y_d = y_next;
          vel_d    = vel_next;
        end
        if (cac_x_q < SPEED_B) begin
          cac_x_d = CAC_START_B;
          score_d = (score_q == 4'd9) ? 4'd0 : score_q + 4'd1;
        end else begin
          cac_x_d = cac_x_q - SPEED_B;
        end
        if (cac_x_d > HIT_X_LO && cac_x_d < HIT_X_HI && dino_y_d > HIT_Y_S) begin
          game_over_d = 1'b1;
        end
      end
    end
    // An edge arriving during UPDATE stays pending for the next frame.
    if (jump_edge) jump_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_INIT;
      idx_q          <= '0;
      cs_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      dino_y_q       <= GROUND_Y_S;
      vel_q          <= '0;
      on_ground_q    <= 1'b1;
      cac_x_q        <= CAC_START_B;
      score_q        <= '0;
      game_over_q    <= 1'b0;
      jump_pending_q <= 1'b0;
      vs_q           <= 1'b1;
      frame_miss_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cs_q           <= cs_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      dino_y_q       <= dino_y_d;
      vel_q          <= vel_d;
      on_ground_q    <= on_ground_d;
      cac_x_q        <= cac_x_d;
      score_q        <= score_d;
      game_over_q    <= game_over_d;
      jump_pending_q <= jump_pending_d;
      vs_q           <= VGA_VS;
      frame_miss_q   <= frame_tick & (state_q != ST_IDLE);
    end
  end

  assign chipselect = cs_q;
  assign write      = cs_q;
  assign address    = addr_q;
  assign writedata  = wdata_q;
  assign game_over  = game_over_q;
  assign frame_miss = frame_miss_q;

endmodule
